axis_rr_arb: RTL and testbench
==============================

Name: axis_rr_arb

Overview:
Packet-granular round-robin arbiter that shares one AXI-stream register pipeline between N_SRC requesters. It sits directly in front of the shared register-slice chain. It locks a grant for a whole packet, from the first beat through the beat carrying tlast. Each beat is forwarded through one internal full-throughput output register, and the winning source index is tagged on m_axis_tid.

Parameters:
N_SRC, 4, number of requesting sources (1..16)
DATA_BITS, 32, tdata width per source and at the output
ID_BITS, $clog2(N_SRC) (minimum 1), width of m_axis_tid

Ports:
aclk  in  1  clock; all logic on rising edge
areset  in  1  asynchronous, active-high reset
s_axis_tvalid  in  N_SRC  per-source valid
s_axis_tready  out  N_SRC  per-source ready
s_axis_tdata  in  N_SRC*DATA_BITS  source i on bits [i*DATA_BITS +: DATA_BITS]
s_axis_tlast  in  N_SRC  per-source end-of-packet
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
m_axis_tdata  out  DATA_BITS  output data
m_axis_tlast  out  1  output end-of-packet
m_axis_tid  out  ID_BITS  index of the source that produced the current output beat
busy  out  1  high while a grant is locked (state LOCK)

Behaviour:
- Reset values (asynchronous):
  - outputs: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tid=0, s_axis_tready=0, busy=0
  - internal: state=IDLE, rr pointer=0, grant=0
- FSM states: IDLE, LOCK.
- IDLE:
  - If any s_axis_tvalid is high, grant = first i with s_axis_tvalid[i]=1, searching upward from the rr pointer with wrap at N_SRC.
  - Register grant, go to LOCK.
  - No beat is accepted in IDLE; all s_axis_tready=0.
- LOCK:
  - s_axis_tready[grant] = !m_axis_tvalid || m_axis_tready. All other tready bits are 0.
  - Beat accept = s_axis_tvalid[grant] && s_axis_tready[grant].
  - On accept: the output register loads tdata/tlast of the granted source, sets m_axis_tid=grant, and sets m_axis_tvalid=1.
  - On accept with tlast=1: rr pointer = (grant+1) mod N_SRC, go to IDLE.
  - If the granted source drops tvalid mid-packet, the grant is held indefinitely (no timeout). Other sources are starved until tlast.
- Output register:
  - Cleared (m_axis_tvalid=0) when m_axis_tready=1 and there is no new accept in that cycle.
  - Accept and drain in the same cycle give back-to-back beats.
- Latency and throughput:
  - A beat accepted at edge t is visible on m_axis_* after edge t.
  - Sustained throughput within a packet is 1 beat/cycle.
  - Exactly one bubble cycle occurs between packets (the IDLE arbitration cycle).
- Output stability: m_axis_tdata/tlast/tid hold steady while m_axis_tvalid=1 and m_axis_tready=0 (AXI-S compliant).
- Single-beat packet (tlast on first beat): LOCK lasts one accepting cycle.
- N_SRC=1:
  - The pointer stays 0.
  - The arbiter degenerates to a register stage with one bubble per packet.
- All sources requesting continuously: grants rotate 0,1,2,...,N_SRC-1,0 with one packet each.
- Request arriving in the same cycle a packet ends: not considered until the next IDLE cycle.
- Reset mid-packet:
  - The in-flight output beat is dropped (m_axis_tvalid=0).
  - State returns to IDLE and the pointer returns to 0.
  - Upstream is responsible for packet resynchronisation.

Optional Feature:
AXIS_ARB_PKT_CNT_EN
- Defined:
  - Adds output port pkt_cnt (N_SRC*32), one 32-bit counter per source at [i*32 +: 32].
  - Counter i increments by 1 on each accepted beat from source i with tlast=1.
  - Counters wrap from 0xFFFFFFFF to 0 and are reset to 0 by areset.
- Undefined: the port and counters are absent. All other behaviour is identical.

Test Plan:
- Reset release with s_axis_tvalid=4'b0000 -> m_axis_tvalid=0, s_axis_tready=0, busy=0 for 10 cycles.
- Src 2 sends a 4-beat packet 0xA0..0xA3, m_axis_tready=1 -> busy rises 1 cycle after tvalid; m_axis_tdata=0xA0..0xA3 on 4 consecutive cycles; tid=2; tlast only on 0xA3; busy drops after the last accept.
- All 4 sources continuously send 2-beat packets -> output tid sequence 0,0,1,1,2,2,3,3,0,0; exactly one bubble cycle between packets.
- Src 1 mid-packet with m_axis_tready toggling 1,0,0,1 -> m_axis_tdata stable while stalled; no beat lost or duplicated; src 0/3 tready stay 0 throughout.
- Src 3 drops tvalid for 5 cycles mid-packet while src 0 requests -> grant stays 3 and src 0 waits; src 0 is granted after src 3's tlast, with pointer wrap 3 -> 0.
- areset asserted on the 2nd beat of a 3-beat packet -> m_axis_tvalid=0 immediately; after release src 1 requests first and is granted (pointer=0). With AXIS_ARB_PKT_CNT_EN: pkt_cnt for each source returns to 0.

Source files
------------

// File: rtl/axis_rr_arb.sv
// Packet-granular round-robin arbiter that feeds one full-throughput AXI-stream output register.
// Define AXIS_ARB_PKT_CNT_EN to add the per-source completed-packet counters on pkt_cnt.
module axis_rr_arb #(
  parameter int N_SRC     = 4,
  parameter int DATA_BITS = 32,
  parameter int ID_BITS   = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [N_SRC-1:0]           s_axis_tvalid,
  output logic [N_SRC-1:0]           s_axis_tready,
  input  logic [N_SRC*DATA_BITS-1:0] s_axis_tdata,
  input  logic [N_SRC-1:0]           s_axis_tlast,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [DATA_BITS-1:0]       m_axis_tdata,
  output logic                       m_axis_tlast,
  output logic [ID_BITS-1:0]         m_axis_tid,
  output logic                       busy
`ifdef AXIS_ARB_PKT_CNT_EN
  ,
  output logic [N_SRC*32-1:0]        pkt_cnt
`endif
);

  typedef enum logic {S_IDLE, S_LOCK} state_t;

  state_t               r_state, w_state_nxt;
  logic [ID_BITS-1:0]   r_ptr, r_grant, w_pick, w_ptr_nxt;
  logic                 r_mvalid, r_mlast;
  logic [DATA_BITS-1:0] r_mdata;
  logic [ID_BITS-1:0]   r_mtid;
  logic                 w_lock, w_any, w_slot_free, w_acc, w_acc_last;
  logic [N_SRC-1:0]     w_sel, w_acc_v, w_acc_last_v;

  function automatic logic [ID_BITS-1:0] wrap_idx(input int v);
    return ID_BITS'((v >= N_SRC) ? (v - N_SRC) : v);
  endfunction

  assign w_lock      = (r_state == S_LOCK);
  assign w_any       = |s_axis_tvalid;
  assign w_slot_free = !r_mvalid || m_axis_tready;
  assign w_acc       = |w_acc_v;
  assign w_acc_last  = |w_acc_last_v;
  assign w_ptr_nxt   = (r_grant == ID_BITS'(N_SRC - 1)) ? '0 : r_grant + ID_BITS'(1);

  // Scan downward so the requester closest above r_ptr is the last (winning) assignment.
  always_comb begin
    w_pick = r_ptr;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (s_axis_tvalid[wrap_idx(int'(r_ptr) + k)]) w_pick = wrap_idx(int'(r_ptr) + k);
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any)      w_state_nxt = S_LOCK;
      S_LOCK:  if (w_acc_last) w_state_nxt = S_IDLE;
      default:                 w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_grant <= '0;
      r_ptr   <= '0;
    end else begin
      if (!w_lock && w_any) r_grant <= w_pick;
      if (w_acc_last)       r_ptr   <= w_ptr_nxt;
    end
  end

  // Per-source handshake slice; only the locked grant ever sees ready.
  for (genvar i = 0; i < N_SRC; i++) begin : g_lane
    assign w_sel[i]         = w_lock && (r_grant == ID_BITS'(i));
    assign s_axis_tready[i] = w_sel[i] && w_slot_free;
    assign w_acc_v[i]       = s_axis_tready[i] && s_axis_tvalid[i];
    assign w_acc_last_v[i]  = w_acc_v[i] && s_axis_tlast[i];
`ifdef AXIS_ARB_PKT_CNT_EN
    logic [31:0] r_cnt;
    always_ff @(posedge aclk or posedge areset) begin
      if (areset)               r_cnt <= '0;
      else if (w_acc_last_v[i]) r_cnt <= r_cnt + 32'd1;
    end
    assign pkt_cnt[i*32 +: 32] = r_cnt;
`endif
  end

  // Output slot: load on accept, otherwise empty it once the consumer takes the beat.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_mvalid <= 1'b0;
      r_mdata  <= '0;
      r_mlast  <= 1'b0;
      r_mtid   <= '0;
    end else if (w_acc) begin
      r_mvalid <= 1'b1;
      r_mdata  <= s_axis_tdata[int'(r_grant)*DATA_BITS +: DATA_BITS];
      r_mlast  <= w_acc_last;
      r_mtid   <= r_grant;
    end else if (m_axis_tready) begin
      r_mvalid <= 1'b0;
    end
  end

  assign m_axis_tvalid = r_mvalid;
  assign m_axis_tdata  = r_mdata;
  assign m_axis_tlast  = r_mlast;
  assign m_axis_tid    = r_mtid;
  assign busy          = w_lock;

endmodule

// File: tb/tb_axis_rr_arb.sv
// Directed bench for axis_rr_arb (N_SRC=4, DATA_BITS=32); sources are modelled as beat counters.
module tb_axis_rr_arb;

  logic         aclk = 1'b0;
  logic         areset;
  logic [3:0]   s_tvalid, s_tready, s_tlast;
  logic [127:0] s_tdata;
  logic         m_tvalid, m_tready, m_tlast, busy;
  logic [31:0]  m_tdata;
  logic [1:0]   m_tid;
`ifdef AXIS_ARB_PKT_CNT_EN
  logic [127:0] pkt_cnt;
`endif

  axis_rr_arb #(.N_SRC(4), .DATA_BITS(32)) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast),
    .m_axis_tid(m_tid), .busy(busy)
`ifdef AXIS_ARB_PKT_CNT_EN
    , .pkt_cnt(pkt_cnt)
`endif
  );

  always #5 aclk = ~aclk;

  int          n_chk = 0;
  int          n_err = 0;
  logic [3:0]  en, hs;
  int          beat [4];
  int          len  [4];
  logic [31:0] base [4];
  int          mr   [5];
  logic [31:0] ex   [5];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    s_tvalid = en;
    for (int i = 0; i < 4; i++) begin
      s_tdata[i*32 +: 32] = base[i] + 32'(beat[i]);
      s_tlast[i]          = (beat[i] == len[i] - 1);
    end
  endtask

  task automatic settle();
    drive();
    #1;
  endtask

  // One clock: record handshakes before the edge, advance source beat counters after it.
  task automatic tick();
    #1;
    hs = s_tvalid & s_tready;
    @(posedge aclk);
    #1;
    for (int i = 0; i < 4; i++)
      if (hs[i]) beat[i] = (beat[i] + 1 == len[i]) ? 0 : beat[i] + 1;
    drive();
    #1;
  endtask

  task automatic clr_src();
    en = '0;
    for (int i = 0; i < 4; i++) begin
      beat[i] = 0;
      len[i]  = 1;
      base[i] = '0;
    end
  endtask

  task automatic do_reset();
    areset = 1'b1;
    clr_src();
    drive();
    #1;
    chk("rst_mvalid", m_tvalid, 0);
    chk("rst_busy", busy, 0);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    #1;
  endtask

  initial begin
    areset   = 1'b0;
    m_tready = 1'b1;
    clr_src();
    drive();
    #1 areset = 1'b1;
    #1;
    chk("por_mvalid", m_tvalid, 0);
    chk("por_mdata", m_tdata, 0);
    chk("por_mlast", m_tlast, 0);
    chk("por_tid", m_tid, 0);
    chk("por_tready", s_tready, 0);
    chk("por_busy", busy, 0);
    @(posedge aclk);
    #2 areset = 1'b0;

    // idle after reset release
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("idle_mvalid", m_tvalid, 0);
      chk("idle_tready", s_tready, 0);
      chk("idle_busy", busy, 0);
    end

    // src 2: 4-beat packet A0..A3
    base[2] = 32'hA0; len[2] = 4; en = 4'b0100;
    settle();
    chk("p2_pre_busy", busy, 0);
    chk("p2_pre_tready", s_tready, 0);
    tick();
    chk("p2_arb_busy", busy, 1);
    chk("p2_arb_mvalid", m_tvalid, 0);
    chk("p2_arb_tready", s_tready, 4'b0100);
    for (int b = 0; b < 4; b++) begin
      tick();
      chk("p2_mvalid", m_tvalid, 1);
      chk("p2_mdata", m_tdata, 32'hA0 + 32'(b));
      chk("p2_tid", m_tid, 2);
      chk("p2_tlast", m_tlast, (b == 3) ? 1 : 0);
    end
    chk("p2_end_busy", busy, 0);
    en = '0;
    settle();
    tick();
    chk("p2_drain_mvalid", m_tvalid, 0);

    // all sources, 2-beat packets back to back
    do_reset();
    for (int i = 0; i < 4; i++) begin
      base[i] = 32'hC0 + 32'(i * 16);
      len[i]  = 2;
    end
    en = 4'b1111;
    settle();
    tick();
    chk("rr_arb_busy", busy, 1);
    chk("rr_arb_mvalid", m_tvalid, 0);
    for (int k = 0; k < 15; k++) begin
      tick();
      if (k % 3 == 2) begin
        chk("rr_bubble", m_tvalid, 0);
      end else begin
        chk("rr_mvalid", m_tvalid, 1);
        chk("rr_tid", m_tid, 32'((k / 3) % 4));
        chk("rr_mdata", m_tdata, 32'hC0 + 32'(((k / 3) % 4) * 16 + (k % 3)));
        chk("rr_tlast", m_tlast, (k % 3 == 1) ? 1 : 0);
      end
      chk("rr_busy", busy, (k % 3 == 1) ? 0 : 1);
    end

    // src 1 with output backpressure; src 0/3 must stay blocked
    do_reset();
    base[1] = 32'h50; len[1] = 4; en = 4'b0010;
    settle();
    tick();
    base[0] = 32'h60; base[3] = 32'h70; en = 4'b1011;
    settle();
    chk("bp_tready0", s_tready, 4'b0010);
    tick();
    chk("bp_first", m_tdata, 32'h50);
    mr = '{1, 0, 0, 1, 1};
    ex = '{32'h51, 32'h51, 32'h51, 32'h52, 32'h53};
    for (int j = 0; j < 5; j++) begin
      m_tready = mr[j][0];
      settle();
      chk("bp_tready", s_tready, mr[j][0] ? 4'b0010 : 4'b0000);
      tick();
      chk("bp_mvalid", m_tvalid, 1);
      chk("bp_mdata", m_tdata, ex[j]);
      chk("bp_tid", m_tid, 1);
      chk("bp_tlast", m_tlast, (j == 4) ? 1 : 0);
    end
    m_tready = 1'b1;
    en = '0;
    settle();
    tick();
    chk("bp_drain_mvalid", m_tvalid, 0);
    chk("bp_drain_busy", busy, 0);

    // src 3 stalls mid-packet while src 0 waits; wrap 3 -> 0 afterwards
    do_reset();
    base[3] = 32'hE0; len[3] = 3; base[0] = 32'hF0; len[0] = 1; en = 4'b1000;
    settle();
    tick();
    tick();
    chk("hold_first", m_tdata, 32'hE0);
    chk("hold_first_tid", m_tid, 3);
    en = 4'b0001;
    settle();
    for (int c = 0; c < 5; c++) begin
      chk("hold_src0_tready", 32'(s_tready[0]), 0);
      tick();
      chk("hold_mvalid", m_tvalid, 0);
      chk("hold_busy", busy, 1);
    end
    en = 4'b1001;
    settle();
    tick();
    chk("hold_b1", m_tdata, 32'hE1);
    chk("hold_b1_tid", m_tid, 3);
    tick();
    chk("hold_b2", m_tdata, 32'hE2);
    chk("hold_b2_tlast", m_tlast, 1);
    chk("hold_b2_busy", busy, 0);
    tick();
    chk("wrap_arb_mvalid", m_tvalid, 0);
    chk("wrap_arb_tready", s_tready, 4'b0001);
    tick();
    chk("wrap_tid", m_tid, 0);
    chk("wrap_mdata", m_tdata, 32'hF0);
    chk("wrap_tlast", m_tlast, 1);
    en = '0;
    settle();
    tick();

    // reset mid-packet after the pointer has moved to 3
    do_reset();
    base[2] = 32'hB0; len[2] = 1; en = 4'b0100;
    settle();
    tick();
    tick();
    chk("mr_single", m_tdata, 32'hB0);
    len[2] = 3; base[2] = 32'hB8;
    settle();
    tick();
    chk("mr_arb_busy", busy, 1);
    tick();
    chk("mr_b0", m_tdata, 32'hB8);
    tick();
    chk("mr_b1", m_tdata, 32'hB9);
    chk("mr_b1_tid", m_tid, 2);
`ifdef AXIS_ARB_PKT_CNT_EN
    chk("mr_cnt_pre", pkt_cnt[64 +: 32], 1);
`endif
    areset = 1'b1;
    clr_src();
    drive();
    #1;
    chk("mr_rst_mvalid", m_tvalid, 0);
    chk("mr_rst_busy", busy, 0);
    chk("mr_rst_tready", s_tready, 0);
    chk("mr_rst_tid", m_tid, 0);
`ifdef AXIS_ARB_PKT_CNT_EN
    chk("mr_rst_cnt", pkt_cnt[64 +: 32], 0);
`endif
    @(posedge aclk);
    #1;
    areset = 1'b0;
    base[1] = 32'h10; base[3] = 32'h30; en = 4'b1010;
    settle();
    tick();
    chk("mr_post_busy", busy, 1);
    chk("mr_post_mvalid", m_tvalid, 0);
    tick();
    chk("mr_post_mvalid2", m_tvalid, 1);
    chk("mr_post_tid", m_tid, 1);
    chk("mr_post_mdata", m_tdata, 32'h10);
    chk("mr_post_tlast", m_tlast, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
